// File: rtl/rf_write_scheduler.sv
// -----------------------------------------------------------------------------
// rf_write_scheduler
//
// Shares the register file's single write port between the in-order pipeline
// writeback and a long-latency unit (multiply/divide). Long-unit results are
// buffered in a small FIFO and drained into cycles the pipeline leaves idle.
// A pending scoreboard marks registers whose long-unit result has not yet been
// written and stalls decode on RAW/WAW hazards against them. If the pipeline
// keeps the port busy for STARVE_LIMIT consecutive cycles while results wait,
// a stall is forced so that a bubble eventually frees the port.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   pipe_wb_en/rd/data         pipeline writeback request (highest priority)
//   lu_valid/ready/rd/data     long-unit result handshake into the FIFO
//   issue_en, issue_rd         long-unit op dispatched from ID (sets pending)
//   chk_rs1, chk_rs2, chk_rd   registers of the instruction in decode
//   stall                      hold IF/ID, bubble ID/EX
//   rf_we, rf_wa, rf_wd        register file write port
//   pending                    scoreboard, bit 0 always 0
//   fifo_count                 current FIFO occupancy
// -----------------------------------------------------------------------------
module rf_write_scheduler #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pipe_wb_en,
    input  logic [4:0]                    pipe_wb_rd,
    input  logic [XLEN-1:0]               pipe_wb_data,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [4:0]                    lu_rd,
    input  logic [XLEN-1:0]               lu_data,
    input  logic                          issue_en,
    input  logic [4:0]                    issue_rd,
    input  logic [4:0]                    chk_rs1,
    input  logic [4:0]                    chk_rs2,
    input  logic [4:0]                    chk_rd,
    output logic                          stall,
    output logic                          rf_we,
    output logic [4:0]                    rf_wa,
    output logic [XLEN-1:0]               rf_wd,
    output logic [31:0]                   pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and state
    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pending_q;
    logic [STV_W-1:0] starve;

    // Control decode
    logic        pipe_wins;
    logic        fifo_empty;
    logic        push;
    logic        drain;
    logic        blocked;
    logic        starved;
    logic [4:0]  head_rd;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] pending_next;

    assign pipe_wins  = pipe_wb_en && (pipe_wb_rd != 5'd0);
    assign fifo_empty = (count == '0);
    assign head_rd    = fifo_rd[rd_ptr];

    // Ready is based on the registered count only, so a same-cycle pop never
    // opens a slot early; held low throughout reset.
    assign lu_ready = !reset && (count < CNT_W'(FIFO_DEPTH));

    // A result for x0 completes the handshake but is dropped.
    assign push    = lu_valid && lu_ready && (lu_rd != 5'd0);
    assign drain   = !reset && !pipe_wins && !fifo_empty;
    assign blocked = pipe_wins && !fifo_empty;
    assign starved = (starve == STV_W'(STARVE_LIMIT));

    // Write-port arbitration: pipeline first, then FIFO head, else idle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = '0;
        if (!reset) begin
            if (pipe_wins) begin
                rf_we = 1'b1;
                rf_wa = pipe_wb_rd;
                rf_wd = pipe_wb_data;
            end else if (!fifo_empty) begin
                rf_we = 1'b1;
                rf_wa = head_rd;
                rf_wd = fifo_data[rd_ptr];
            end
        end
    end

    // Scoreboard update: a new issue to the same register outranks the drain
    // of an older result to it.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_en && (issue_rd != 5'd0)) begin
            set_mask = 32'd1 << issue_rd;
        end
        if (drain) begin
            clr_mask = 32'd1 << head_rd;
        end
        pending_next = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Hazard stall: RAW on either source, WAW on the destination, or forced
    // bubble once the FIFO head has been starved for too long.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            if ((chk_rs1 != 5'd0) && pending_q[chk_rs1]) stall = 1'b1;
            if ((chk_rs2 != 5'd0) && pending_q[chk_rs2]) stall = 1'b1;
            if ((chk_rd  != 5'd0) && pending_q[chk_rd])  stall = 1'b1;
            if (starved)                                 stall = 1'b1;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pending_q <= '0;
            starve    <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (drain) rd_ptr <= rd_ptr + PTR_W'(1);

            unique case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            pending_q <= pending_next;

            if (fifo_empty || drain) begin
                starve <= '0;
            end else if (blocked && !starved) begin
                starve <= starve + STV_W'(1);
            end
        end
    end

    // FIFO payload storage
    // NOTE: the payload array is deliberately not reset; entries are only
    // visible through the pointers and count, which are.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lu_rd;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

    assign pending    = pending_q;
    assign fifo_count = count;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rf_write_scheduler
//
// Directed testbench for rf_write_scheduler with default parameters
// (XLEN=32, FIFO_DEPTH=2, STARVE_LIMIT=4). Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_rf_write_scheduler;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_wb_en;
    logic [4:0]      pipe_wb_rd;
    logic [XLEN-1:0] pipe_wb_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            issue_en;
    logic [4:0]      issue_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            stall;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic [31:0]     pending;
    logic [1:0]      fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    rf_write_scheduler #(
        .XLEN(XLEN),
        .FIFO_DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pipe_wb_en(pipe_wb_en),
        .pipe_wb_rd(pipe_wb_rd),
        .pipe_wb_data(pipe_wb_data),
        .lu_valid(lu_valid),
        .lu_ready(lu_ready),
        .lu_rd(lu_rd),
        .lu_data(lu_data),
        .issue_en(issue_en),
        .issue_rd(issue_rd),
        .chk_rs1(chk_rs1),
        .chk_rs2(chk_rs2),
        .chk_rd(chk_rd),
        .stall(stall),
        .rf_we(rf_we),
        .rf_wa(rf_wa),
        .rf_wd(rf_wd),
        .pending(pending),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [4:0] exp_wa [4];

    initial begin
        exp_wa[0] = 5'd12;
        exp_wa[1] = 5'd13;
        exp_wa[2] = 5'd14;
        exp_wa[3] = 5'd14;

        // ---------------- reset with pipeline active ----------------
        reset        = 1'b1;
        pipe_wb_en   = 1'b1;
        pipe_wb_rd   = 5'd5;
        pipe_wb_data = 32'hDEAD_BEEF;
        lu_valid     = 1'b1;
        lu_rd        = 5'd2;
        lu_data      = 32'h0;
        issue_en     = 1'b0;
        issue_rd     = 5'd0;
        chk_rs1      = 5'd0;
        chk_rs2      = 5'd0;
        chk_rd       = 5'd0;
        step();
        step();
        check("rst_rf_we", rf_we, 0);
        check("rst_lu_ready", lu_ready, 0);
        check("rst_stall", stall, 0);
        check("rst_pending", pending, 0);
        check("rst_count", fifo_count, 0);

        // ---------------- first pipeline write after release ----------------
        reset        = 1'b0;
        lu_valid     = 1'b0;
        pipe_wb_data = 32'hA5A5_0001;
        settle();
        check("pipe_we", rf_we, 1);
        check("pipe_wa", rf_wa, 5);
        check("pipe_wd", rf_wd, 32'hA5A5_0001);
        check("post_rst_ready", lu_ready, 1);

        // ---------------- issue rd=7, then result ----------------
        step();
        pipe_wb_en = 1'b0;
        issue_en   = 1'b1;
        issue_rd   = 5'd7;
        chk_rs1    = 5'd7;
        step();
        issue_en = 1'b0;
        settle();
        check("pend7_set", pending[7], 1);
        check("raw_stall_a", stall, 1);
        lu_valid = 1'b1;
        lu_rd    = 5'd7;
        lu_data  = 32'h1234;
        settle();
        check("no_bypass_we", rf_we, 0);
        step();
        lu_valid = 1'b0;
        settle();
        check("lu7_count", fifo_count, 1);
        check("lu7_we", rf_we, 1);
        check("lu7_wa", rf_wa, 7);
        check("lu7_wd", rf_wd, 32'h1234);
        check("raw_stall_b", stall, 1);
        step();
        check("pend7_clr", pending[7], 0);
        check("raw_release", stall, 0);
        check("lu7_empty", fifo_count, 0);
        check("lu7_idle_we", rf_we, 0);

        // ---------------- result to x0 is dropped ----------------
        chk_rs1  = 5'd0;
        lu_valid = 1'b1;
        lu_rd    = 5'd0;
        lu_data  = 32'hFFFF_0000;
        settle();
        check("x0_ready", lu_ready, 1);
        step();
        lu_valid = 1'b0;
        settle();
        check("x0_count", fifo_count, 0);
        check("x0_we", rf_we, 0);

        // ---------------- starvation under continuous pipeline writes ----------------
        pipe_wb_en   = 1'b1;
        pipe_wb_rd   = 5'd1;
        pipe_wb_data = 32'h0000_0011;
        lu_valid     = 1'b1;
        lu_rd        = 5'd3;
        lu_data      = 32'h0000_0033;
        step();
        lu_rd   = 5'd4;
        lu_data = 32'h0000_0044;
        step();
        lu_rd   = 5'd5;
        lu_data = 32'h0000_0055;
        settle();
        check("full_count", fifo_count, 2);
        check("full_ready", lu_ready, 0);
        check("blocked_wa", rf_wa, 1);
        check("starve1_stall", stall, 0);
        step();
        check("no_third_push", fifo_count, 2);
        step();
        check("starve3_stall", stall, 0);
        step();
        check("starve4_stall", stall, 1);
        step();
        check("starve_sat_stall", stall, 1);
        lu_valid   = 1'b0;
        pipe_wb_en = 1'b0;
        settle();
        check("drain3_wa", rf_wa, 3);
        check("drain3_wd", rf_wd, 32'h0000_0033);
        step();
        check("starve_clr_stall", stall, 0);
        check("drain4_wa", rf_wa, 4);
        check("drain4_wd", rf_wd, 32'h0000_0044);
        check("drain4_count", fifo_count, 1);
        step();
        check("drained_count", fifo_count, 0);
        check("drained_we", rf_we, 0);

        // ---------------- drain and issue of rd=9 in the same cycle ----------------
        issue_en = 1'b1;
        issue_rd = 5'd9;
        step();
        issue_en = 1'b0;
        lu_valid = 1'b1;
        lu_rd    = 5'd9;
        lu_data  = 32'h0000_0099;
        step();
        lu_valid = 1'b0;
        issue_en = 1'b1;
        issue_rd = 5'd9;
        settle();
        check("drain9_wa", rf_wa, 9);
        step();
        issue_en = 1'b0;
        settle();
        check("pend9_set_wins", pending[9], 1);
        check("drain9_count", fifo_count, 0);

        // ---------------- full FIFO streaming, then reset mid-stream ----------------
        pipe_wb_en = 1'b1;
        pipe_wb_rd = 5'd1;
        lu_valid   = 1'b1;
        lu_rd      = 5'd12;
        lu_data    = 32'h0000_0C12;
        issue_en   = 1'b1;
        issue_rd   = 5'd20;
        step();
        issue_en = 1'b0;
        lu_rd    = 5'd13;
        lu_data  = 32'h0000_0C13;
        step();
        pipe_wb_en = 1'b0;
        lu_rd      = 5'd14;
        lu_data    = 32'h0000_0C14;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (fifo_count == 2'd2) check($sformatf("stream_ready_%0d", i), lu_ready, 0);
            check($sformatf("stream_cnt_le_%0d", i), (fifo_count <= 2'd2), 1);
            check($sformatf("stream_we_%0d", i), rf_we, 1);
            check($sformatf("stream_wa_%0d", i), rf_wa, exp_wa[i]);
            step();
        end
        chk_rs1 = 5'd20;
        settle();
        check("pend20_stall", stall, 1);
        reset = 1'b1;
        settle();
        check("midrst_we", rf_we, 0);
        check("midrst_ready", lu_ready, 0);
        check("midrst_stall", stall, 0);
        step();
        reset    = 1'b0;
        lu_valid = 1'b0;
        settle();
        check("midrst_count", fifo_count, 0);
        check("midrst_pending", pending, 0);
        check("midrst_no_stall", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
